// File: rtl/serial_frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// State encoding, line levels and a counter-width helper.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width needed to count n distinct values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit cycle timer: counts CLKS_PER_BIT cycles and strobes bit_end on the last one.
// Counts down from 0 -> CLKS_PER_BIT-1 -> ... -> 0, so each bit spans exactly CLKS_PER_BIT cycles.
module serial_frame_tx_bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d   = (cnt_q == '0) ? LAST : cnt_q - CW'(1);
    bit_end = enable && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// Each bit is held CLKS_PER_BIT cycles; all outputs except outReady are registered.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              inClk,
  input  logic              inRst,
  input  logic [DATA_W-1:0] inData,
  input  logic              inValid,
  output logic              outReady,
  output logic              outTx,
  output logic              outBusy,
  output logic              outDone
);

  localparam int unsigned BW = cnt_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_shifted;
  logic [BW-1:0]     bit_idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              bit_end;

  assign outReady      = (state_q == IDLE);
  assign accept        = inValid && outReady;
  assign shreg_shifted = shreg_q >> 1;

  serial_frame_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (inClk),
    .rst    (inRst),
    .clear  (accept),
    .enable (busy_q),
    .bit_end(bit_end)
  );

  // The line level is registered one step ahead: each transition loads the level
  // for the bit that starts on the following cycle.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= LINE_IDLE;
          if (accept) begin
            shreg_q   <= inData;
            bit_idx_q <= '0;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_BIT) begin
              tx_q    <= STOP_BIT;
              state_q <= STOP;
            end else begin
              shreg_q   <= shreg_shifted;
              bit_idx_q <= bit_idx_q + BW'(1);
              tx_q      <= shreg_shifted[0];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign outTx   = tx_q;
  assign outBusy = busy_q;
  assign outDone = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed self-checking bench for serial_frame_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] data1;
  logic       valid1;
  logic       ready1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int total;
  int bad;

  serial_frame_tx #(
    .DATA_W      (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .inClk   (clk),
    .inRst   (rst),
    .inData  (data),
    .inValid (valid),
    .outReady(ready),
    .outTx   (tx),
    .outBusy (busy),
    .outDone (done)
  );

  serial_frame_tx #(
    .DATA_W      (8),
    .CLKS_PER_BIT(1)
  ) dut1 (
    .inClk   (clk),
    .inRst   (rst),
    .inData  (data1),
    .inValid (valid1),
    .outReady(ready1),
    .outTx   (tx1),
    .outBusy (busy1),
    .outDone (done1)
  );

  always #5 clk = ~clk;

  // Frame words, bit 0 is the first bit on the line: {stop, data, start}.
  localparam logic [9:0] SEQ_A5 = 10'b1101001010;
  localparam logic [9:0] SEQ_00 = 10'b1000000000;
  localparam logic [9:0] SEQ_FF = 10'b1111111110;
  localparam logic [9:0] SEQ_81 = 10'b1100000010;
  localparam logic [9:0] SEQ_01 = 10'b1000000010;

  // Observed vector everywhere is {tx, busy, done, ready}.
  // Called at #1 after an edge with the word already presented; the next edge accepts it.
  task automatic watch_frame(input logic [9:0] seq, input bit keep_valid, input int poke_k,
                             input string name);
    logic [3:0] exp;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      exp = {seq[(k-1)/4], 3'b100};
      total++;
      if ({tx, busy, done, ready} !== exp) begin
        bad++;
        $display("FAIL %s cycle T+%0d: got %b want %b", name, k, {tx, busy, done, ready}, exp);
      end
      if (k == 1 && !keep_valid) valid = 1'b0;
      if (k == poke_k) begin
        data  = 8'h3C;
        valid = 1'b1;
      end
      if (poke_k != 0 && k == poke_k + 1) valid = 1'b0;
    end
    @(posedge clk);
    #1;
    total++;
    if ({tx, busy, done, ready} !== 4'b1011) begin
      bad++;
      $display("FAIL %s done cycle T+41: got %b want %b", name, {tx, busy, done, ready}, 4'b1011);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    valid  = 1'b1;
    data   = 8'hA5;
    valid1 = 1'b1;
    data1  = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({tx, busy, done, ready} !== 4'b1001) begin
        bad++;
        $display("FAIL reset cyc%0d: got %b want %b", i, {tx, busy, done, ready}, 4'b1001);
      end
      total++;
      if ({tx1, busy1, done1, ready1} !== 4'b1001) begin
        bad++;
        $display("FAIL reset_cpb1 cyc%0d: got %b want %b", i, {tx1, busy1, done1, ready1}, 4'b1001);
      end
    end
    rst    = 1'b0;
    valid  = 1'b0;
    valid1 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({tx, busy, done, ready} !== 4'b1001) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", {tx, busy, done, ready}, 4'b1001);
    end
  endtask

  task automatic test_frame_a5();
    data  = 8'hA5;
    valid = 1'b1;
    watch_frame(SEQ_A5, 1'b0, 0, "frame_a5");
    @(posedge clk);
    #1;
    total++;
    if ({tx, busy, done, ready} !== 4'b1001) begin
      bad++;
      $display("FAIL frame_a5_after_done: got %b want %b", {tx, busy, done, ready}, 4'b1001);
    end
  endtask

  task automatic test_back_to_back();
    data  = 8'h00;
    valid = 1'b1;
    watch_frame(SEQ_00, 1'b1, 0, "b2b_first");
    // Still in the done cycle with valid high: the next edge must accept 8'hFF.
    data = 8'hFF;
    watch_frame(SEQ_FF, 1'b0, 0, "b2b_second");
    @(posedge clk);
    #1;
    total++;
    if ({tx, busy, done, ready} !== 4'b1001) begin
      bad++;
      $display("FAIL b2b_tail: got %b want %b", {tx, busy, done, ready}, 4'b1001);
    end
  endtask

  task automatic test_ignore_busy_input();
    data  = 8'hA5;
    valid = 1'b1;
    watch_frame(SEQ_A5, 1'b0, 10, "ignore_busy");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({tx, busy, done, ready} !== 4'b1001) begin
        bad++;
        $display("FAIL ignore_busy_no_second cyc%0d: got %b want %b", i, {tx, busy, done, ready},
                 4'b1001);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] exp;
    int         dones;
    data  = 8'hA5;
    valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      exp = {SEQ_A5[(k-1)/4], 3'b100};
      total++;
      if ({tx, busy, done, ready} !== exp) begin
        bad++;
        $display("FAIL rst_mid_pre cycle T+%0d: got %b want %b", k, {tx, busy, done, ready}, exp);
      end
      if (k == 1) valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({tx, busy, done, ready} !== 4'b1001) begin
      bad++;
      $display("FAIL rst_mid_abort: got %b want %b", {tx, busy, done, ready}, 4'b1001);
    end
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL rst_mid_quiet: got %0d active cycles want 0", dones);
    end
    data  = 8'h81;
    valid = 1'b1;
    watch_frame(SEQ_81, 1'b0, 0, "rst_mid_81");
  endtask

  task automatic test_cpb1();
    logic [3:0] exp;
    data1  = 8'h01;
    valid1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      exp = {SEQ_01[k-1], 3'b100};
      total++;
      if ({tx1, busy1, done1, ready1} !== exp) begin
        bad++;
        $display("FAIL cpb1 cycle T+%0d: got %b want %b", k, {tx1, busy1, done1, ready1}, exp);
      end
      if (k == 1) valid1 = 1'b0;
    end
    @(posedge clk);
    #1;
    total++;
    if ({tx1, busy1, done1, ready1} !== 4'b1011) begin
      bad++;
      $display("FAIL cpb1_done T+11: got %b want %b", {tx1, busy1, done1, ready1}, 4'b1011);
    end
    @(posedge clk);
    #1;
    total++;
    if ({tx1, busy1, done1, ready1} !== 4'b1001) begin
      bad++;
      $display("FAIL cpb1_after: got %b want %b", {tx1, busy1, done1, ready1}, 4'b1001);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    data   = 8'h00;
    valid  = 1'b0;
    data1  = 8'h00;
    valid1 = 1'b0;
    total  = 0;
    bad    = 0;
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_ignore_busy_input();
    test_reset_mid_frame();
    test_cpb1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter built on clocked registers. It is the transmit end that drives a single-wire serial line, which a DFF-based receiver/deserializer samples.
- Accepts one DATA_W word per valid/ready handshake. Sends it LSB-first as one start bit (0), DATA_W data bits, and one stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.

Parameters:
DATA_W, 8, payload width in bits (>= 1)
CLKS_PER_BIT, 4, clock cycles per serial bit (>= 1)

Ports:
inClk  input  1  clock; all state updates on rising edge
inRst  input  1  synchronous, active-high reset
inData  input  DATA_W  word to transmit; sampled only at acceptance
inValid  input  1  inData valid
outReady  output  1  high when the block can accept a word (state IDLE)
outTx  output  1  serial line; idle level 1
outBusy  output  1  high while a frame is on the line (START/DATA/STOP)
outDone  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Clocking and reset: one clock, inClk. Reset is synchronous and active-high on inRst.
- Reset values: state=IDLE, outTx=1, outReady=1, outBusy=0, outDone=0, bit counter=0, cycle counter=0.
- Reset mid-frame aborts the frame. outTx returns to 1 on the next edge; no outDone pulse is generated.
- All outputs are registered, except outReady = (state==IDLE).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - outTx=1.
  - When inValid && outReady at edge T: latch inData into a shift register, clear the counters, go to START.
  - outTx=0 from cycle T+1.
- START: hold outTx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - outTx = shreg[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After bit DATA_W-1, go to STOP.
- STOP: outTx=1 for CLKS_PER_BIT cycles, then go to IDLE and set outDone=1 for exactly that first IDLE cycle.
- Frame length is (DATA_W+2)*CLKS_PER_BIT cycles, from T+1 to T+(DATA_W+2)*CLKS_PER_BIT inclusive.
- outDone is high at cycle T+(DATA_W+2)*CLKS_PER_BIT+1.
- Back-to-back: a new word may be accepted in the outDone cycle. This gives exactly one idle-high cycle between frames.
- inValid while busy is ignored (no queuing). Changes on inData after acceptance do not affect the frame in flight.
- inRst has priority over acceptance in the same cycle.
- Cycle counter width: $clog2(CLKS_PER_BIT), minimum 1. It wraps 0..CLKS_PER_BIT-1.
- Bit counter width: $clog2(DATA_W), minimum 1.
- CLKS_PER_BIT=1 needs no special case: every state lasts one cycle.
- outBusy = state in {START, DATA, STOP}. outBusy and outReady are mutually exclusive and never both low.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - line level constants (LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1).
- One sub-module is natural: bit_timer. It is a CLKS_PER_BIT down-counter with synchronous clear and a one-cycle bit_end strobe, instantiated once and cleared on acceptance.
- The FSM, shift register and bit index stay in the top module.

Test Plan:
1. Reset: assert inRst 3 cycles with inValid=1 -> outTx=1, outReady=1, outBusy=0, outDone=0 throughout; no frame starts.
2. DATA_W=8, CLKS_PER_BIT=4, inData=8'hA5 accepted at cycle T:
   - outTx per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1;
   - outBusy high T+1..T+40; outDone high only at T+41.
3. Back-to-back 8'h00 then 8'hFF, inValid held high:
   - the second acceptance occurs in the outDone cycle;
   - exactly one outTx=1 gap cycle separates the frames; the second frame is 0, eight 1s, 1.
4. inData changed to 8'h3C and inValid pulsed during a frame of 8'hA5 -> the line still carries 8'hA5 and no second frame starts.
5. inRst asserted at T+15 (mid-DATA) -> outTx=1 and outReady=1 at T+16; no outDone; a fresh 8'h81 afterwards transmits correctly.
6. CLKS_PER_BIT=1, DATA_W=8, inData=8'h01 -> outTx sequence 0,1,0,0,0,0,0,0,0,1 over cycles T+1..T+10; outDone at T+11.
